// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deserializer (FSM state encoding,
// default word width, bit-counter sizing).
package sipo_pkg;

  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } sipo_state_e;

  // One extra bit so the counter can hold DATA_W itself without wrapping.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Shift/insert datapath for the SIPO deserializer. word_d_o is the register's
// next-state value, so the FSM can latch a completed word on the same edge.
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_d_o
);

  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] fresh;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sh_q[DATA_W-2:0], bit_i};
      fresh   = {{(DATA_W-1){1'b0}}, bit_i};
    end else begin
      shifted = {bit_i, sh_q[DATA_W-1:1]};
      fresh   = {bit_i, {(DATA_W-1){1'b0}}};
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns sh_d and no latch is inferred.
    sh_d = sh_q;
    if (load_i) begin
      sh_d = fresh;
    end else if (shift_i) begin
      sh_d = shifted;
    end
  end

  // NOTE: non-blocking for registered state so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign word_d_o = sh_d;

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial-in, parallel-out deserializer with one-cycle ld strobe.
// Define SIPO_PARITY_EN to add an even-parity bit per frame and a par_err port.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              sin_start,
  output logic [DATA_W-1:0] data_out,
  output logic              ld,
  output logic              busy,
  output logic              frame_err
`ifdef SIPO_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sipo_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              ld_q;
  logic              busy_q;
  logic              frame_err_q;
`ifdef SIPO_PARITY_EN
  logic              par_err_q;
`endif

  logic              start_hit;
  logic              shift_en;
  logic [DATA_W-1:0] word_d;

  // A start always reloads the datapath, so an abort discards the partial word.
  assign start_hit = sin_valid & sin_start;
  assign shift_en  = sin_valid & ~sin_start & (state_q == SHIFT);

  sipo_shreg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start_hit),
    .shift_i (shift_en),
    .bit_i   (sin),
    .word_d_o(word_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      ld_q        <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      ld_q        <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (start_hit) begin
        frame_err_q <= (state_q != IDLE);
        state_q     <= SHIFT;
        cnt_q       <= CNT_ONE;
        busy_q      <= 1'b1;
      end else if (sin_valid) begin
        case (state_q)
          SHIFT: begin
            if (cnt_q == LAST_IDX) begin
`ifdef SIPO_PARITY_EN
              state_q <= PAR;
              cnt_q   <= cnt_q + CNT_ONE;
`else
              data_q  <= word_d;
              ld_q    <= 1'b1;
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PAR: begin
`ifdef SIPO_PARITY_EN
            // The shifter is frozen in PAR, so word_d is the received word.
            if (^{word_d, sin}) begin
              par_err_q <= 1'b1;
            end else begin
              data_q <= word_d;
              ld_q   <= 1'b1;
            end
`endif
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            // Valid bits without a start are dropped while idle.
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign ld        = ld_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SIPO_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule
